// File: rtl/ndma_burst_read_mgr_if.sv
// OBI bus bundle used by the NanoDMA read manager.
// Manager/Subordinate modports follow OBI naming; master/slave are the same views
// under the names used by other NanoDMA blocks.
interface OBI_BUS #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Address phase
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    aid;
  logic                    a_optional;
  // Response phase
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rid;
  logic                    err;
  logic                    r_optional;

  modport Manager (
    output req, addr, we, be, wdata, aid, a_optional, rready,
    input  gnt, rvalid, rdata, rid, err, r_optional
  );

  modport Subordinate (
    input  req, addr, we, be, wdata, aid, a_optional, rready,
    output gnt, rvalid, rdata, rid, err, r_optional
  );

  modport master (
    output req, addr, we, be, wdata, aid, a_optional, rready,
    input  gnt, rvalid, rdata, rid, err, r_optional
  );

  modport slave (
    input  req, addr, we, be, wdata, aid, a_optional, rready,
    output gnt, rvalid, rdata, rid, err, r_optional
  );
endinterface

// File: rtl/ndma_burst_read_mgr.sv
// NanoDMA burst read manager: issues len_i consecutive OBI word reads from
// base_addr_i with up to MAX_OUTST in flight, buffers the read data in a small
// FIFO and hands it out on a valid/ready stream.
// Optional feature macro: NDMA_RD_ERR_EN (OBI error responses abort the burst
// and raise the sticky err_o flag).
//
// Handshakes: a stream beat moves on every cycle where rvalid_o & rready_i are
// both 1; rdata_o is held while rvalid_o=1 and rready_i=0. On OBI, an address
// transfer happens on req & gnt (addr held while req waits for gnt) and each
// rvalid is one in-order response; OBI rready is driven 1 because FIFO space is
// reserved before every request.
module ndma_burst_read_mgr #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int MAX_OUTST  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        dbg_state_o,
  OBI_BUS.Manager           read_mgr
);

  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int SW  = CW + 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_issue_cnt;
  logic [LEN_W-1:0]    r_resp_cnt;
  logic [OW-1:0]       r_outst;
  logic                r_done;
  logic                r_err;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [CW-1:0]       r_fifo_cnt;

  logic [SW-1:0]       w_inflight;
  logic                w_req;
  logic                w_gnt;
  logic                w_resp;
  logic                w_err_rsp;
  logic                w_push;
  logic                w_pop;
  logic [OW-1:0]       w_outst_nxt;

  // Words already promised to the FIFO: in flight on OBI plus stored.
  assign w_inflight = SW'(r_outst) + SW'(r_fifo_cnt);

  assign w_req  = (r_state == S_ISSUE) && (r_issue_cnt != '0) &&
                  (r_outst < OW'(MAX_OUTST)) && (w_inflight < SW'(FIFO_DEPTH));
  assign w_gnt  = w_req & read_mgr.gnt;
  // Responses with nothing outstanding belong to requests from before a reset.
  assign w_resp = read_mgr.rvalid & (r_outst != '0);

`ifdef NDMA_RD_ERR_EN
  assign w_err_rsp = w_resp & read_mgr.err;
`else
  assign w_err_rsp = 1'b0;
`endif

  // After an error, the remaining responses of the burst are consumed but dropped.
  assign w_push = w_resp & ~w_err_rsp & ~r_err & (r_fifo_cnt != CW'(FIFO_DEPTH));
  assign w_pop  = rvalid_o & rready_i;

  assign w_outst_nxt = r_outst + OW'(w_gnt) - OW'(w_resp);

  assign read_mgr.req        = w_req;
  assign read_mgr.addr       = r_addr;
  assign read_mgr.we         = 1'b0;
  assign read_mgr.be         = '1;
  assign read_mgr.wdata      = '0;
  assign read_mgr.aid        = 1'b0;
  assign read_mgr.a_optional = 1'b0;
  assign read_mgr.rready     = 1'b1;

  assign rdata_o     = r_mem[r_rptr];
  assign rvalid_o    = (r_fifo_cnt != '0);
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign dbg_state_o = r_state;

  // Burst control FSM with its address, length and outstanding counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_resp_cnt  <= '0;
      r_outst     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_outst <= w_outst_nxt;
      if (w_resp) begin
        r_resp_cnt <= r_resp_cnt - LEN_W'(1);
      end
      if (w_gnt) begin
        r_addr      <= r_addr + ADDR_INC;
        r_issue_cnt <= r_issue_cnt - LEN_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_err <= 1'b0;
            if (len_i != '0) begin
              r_state     <= S_ISSUE;
              r_addr      <= base_addr_i;
              r_issue_cnt <= len_i;
              r_resp_cnt  <= len_i;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_gnt && (r_issue_cnt == LEN_W'(1))) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((r_resp_cnt == '0) && (r_fifo_cnt == '0)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // An error stops issuing; only the still-outstanding responses are awaited.
      if (w_err_rsp) begin
        r_err       <= 1'b1;
        r_issue_cnt <= '0;
        r_resp_cnt  <= LEN_W'(w_outst_nxt);
        if (r_state == S_ISSUE) begin
          r_state <= S_DRAIN;
        end
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_fifo_cnt <= r_fifo_cnt + CW'(1);
      end else if (!w_push && w_pop) begin
        r_fifo_cnt <= r_fifo_cnt - CW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= read_mgr.rdata;
    end
  end

endmodule

// File: tb/tb_ndma_burst_read_mgr.sv
// Testbench for ndma_burst_read_mgr: OBI subordinate model with in-order
// responses one cycle after grant, stream scoreboard, and per-scenario tasks.
module tb_ndma_burst_read_mgr;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base;
  logic [15:0] len;
  logic        rready;
  logic [31:0] rdata_o;
  logic        rvalid_o, busy_o, done_o, err_o;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  OBI_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ndma_burst_read_mgr #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(16), .MAX_OUTST(2), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base),
    .len_i(len), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .dbg_state_o(dbg_state),
    .read_mgr(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // ---------------- OBI subordinate model ----------------
  bit          gnt_rand = 0;
  bit          rsp_en   = 1;
  bit          rsp_rand = 0;
  int          err_at   = -1;
  int          rsp_idx  = 0;
  bit          p_acc    = 0;
  logic [31:0] p_addr   = '0;
  logic [31:0] pend_q[$];
  logic [31:0] acc_addr_q[$];
  int          acc_cyc_q[$];
  int          n_acc    = 0;

  initial begin
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    bus.rid = 1'b0; bus.err = 1'b0; bus.r_optional = 1'b0;
  end

  always @(negedge clk) begin : model_b
    logic [31:0] a;
    if (p_acc) begin
      pend_q.push_back(p_addr);
      acc_addr_q.push_back(p_addr);
      acc_cyc_q.push_back(cyc);
      n_acc++;
    end
    if (pend_q.size() != 0 && rsp_en && (!rsp_rand || $urandom_range(0, 1) == 1)) begin
      a = pend_q.pop_front();
      bus.rvalid = 1'b1;
      bus.rdata  = data_of(a);
      bus.err    = (rsp_idx == err_at);
      rsp_idx++;
    end else begin
      bus.rvalid = 1'b0;
      bus.rdata  = '0;
      bus.err    = 1'b0;
    end
    bus.gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    p_acc   = bus.req & bus.gnt;
    p_addr  = bus.addr;
  end

  // ---------------- stream scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_beats = 0;
  int n_done  = 0;

  always @(negedge clk) begin : mon_b
    logic [31:0] e;
    if (rst_n) begin
      if (rvalid_o && rready) begin
        n_checks++;
        n_beats++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat_unexpected: got %h, required no beat", rdata_o);
        end else begin
          e = exp_q.pop_front();
          if (rdata_o !== e) $display("FAIL beat_data: got %h, required %h", rdata_o, e);
          else n_pass++;
        end
      end
      if (done_o) begin
        n_done++;
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL busy_at_done: got %b, required 0", busy_o);
        else n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit rr_rand = 0;

  task automatic start_burst(input logic [31:0] b, input logic [15:0] l, input int n_exp);
    for (int i = 0; i < n_exp; i++) exp_q.push_back(data_of(b + 32'(i) * 32'd4));
    @(posedge clk); #1;
    start = 1'b1; base = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int  d0;
    bit  hit;
    d0  = n_done;
    hit = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rr_rand) rready = 1'($urandom_range(0, 1));
      if (n_done != d0) begin
        hit = 1;
        break;
      end
    end
    n_checks++;
    if (!hit) $display("FAIL %s_timeout: done_o not seen in %0d cycles, required done", name, budget);
    else n_pass++;
  endtask

  task automatic clear_log();
    acc_addr_q.delete();
    acc_cyc_q.delete();
    n_acc   = 0;
    n_beats = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base = '0; len = '0; rready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rvalid_o !== 1'b0) $display("FAIL rst_rvalid: got %b, required 0", rvalid_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy_o); else n_pass++;
    n_checks++; if (done_o !== 1'b0) $display("FAIL rst_done: got %b, required 0", done_o); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b, required 0", err_o); else n_pass++;
    n_checks++; if (bus.req !== 1'b0) $display("FAIL rst_req: got %b, required 0", bus.req); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d, required 0", dbg_state); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int d0;
    clear_log();
    d0 = n_done;
    start_burst(32'h0000_1000, 16'd4, 4);
    n_checks++; if (bus.req !== 1'b1) $display("FAIL t1_first_req: got %b, required 1", bus.req); else n_pass++;
    n_checks++; if (bus.addr !== 32'h1000) $display("FAIL t1_first_addr: got %h, required 00001000", bus.addr); else n_pass++;
    wait_done(50, "t1");
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (n_acc !== 4) $display("FAIL t1_req_count: got %0d, required 4", n_acc); else n_pass++;
    for (int i = 0; i < acc_addr_q.size() && i < 4; i++) begin
      n_checks++;
      if (acc_addr_q[i] !== 32'h1000 + 32'(i) * 4) $display("FAIL t1_addr%0d: got %h, required %h", i, acc_addr_q[i], 32'h1000 + 32'(i) * 4);
      else n_pass++;
      n_checks++;
      if (acc_cyc_q[i] !== acc_cyc_q[0] + i) $display("FAIL t1_cycle%0d: got %0d, required %0d", i, acc_cyc_q[i], acc_cyc_q[0] + i);
      else n_pass++;
    end
    n_checks++; if (n_beats !== 4) $display("FAIL t1_beats: got %0d, required 4", n_beats); else n_pass++;
    n_checks++; if (n_done - d0 !== 1) $display("FAIL t1_done_pulses: got %0d, required 1", n_done - d0); else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_log();
    rready = 1'b0;
    start_burst(32'h0000_2000, 16'd8, 8);
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (n_acc !== 4) $display("FAIL t2_stall_reqs: got %0d, required 4", n_acc); else n_pass++;
    n_checks++; if (bus.req !== 1'b0) $display("FAIL t2_stall_req: got %b, required 0", bus.req); else n_pass++;
    n_checks++; if (rvalid_o !== 1'b1) $display("FAIL t2_hold_valid: got %b, required 1", rvalid_o); else n_pass++;
    n_checks++; if (rdata_o !== data_of(32'h2000)) $display("FAIL t2_hold_data: got %h, required %h", rdata_o, data_of(32'h2000)); else n_pass++;
    n_checks++; if (dbg_state !== 2'd1) $display("FAIL t2_state: got %0d, required 1", dbg_state); else n_pass++;
    rready = 1'b1;
    wait_done(80, "t2");
    n_checks++; if (n_beats !== 8) $display("FAIL t2_beats: got %0d, required 8", n_beats); else n_pass++;
    n_checks++; if (n_acc !== 8) $display("FAIL t2_reqs: got %0d, required 8", n_acc); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] ea[3];
    ea[0] = 32'hFFFF_FFF8; ea[1] = 32'hFFFF_FFFC; ea[2] = 32'h0000_0000;
    clear_log();
    start_burst(32'hFFFF_FFF8, 16'd3, 3);
    wait_done(50, "t3");
    n_checks++; if (n_acc !== 3) $display("FAIL t3_reqs: got %0d, required 3", n_acc); else n_pass++;
    for (int i = 0; i < acc_addr_q.size() && i < 3; i++) begin
      n_checks++;
      if (acc_addr_q[i] !== ea[i]) $display("FAIL t3_addr%0d: got %h, required %h", i, acc_addr_q[i], ea[i]);
      else n_pass++;
    end
    n_checks++; if (n_beats !== 3) $display("FAIL t3_beats: got %0d, required 3", n_beats); else n_pass++;
  endtask

  task automatic test_empty();
    clear_log();
    start_burst(32'h0000_3000, 16'd0, 0);
    n_checks++; if (done_o !== 1'b1) $display("FAIL t4_done: got %b, required 1", done_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL t4_busy: got %b, required 0", busy_o); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (done_o !== 1'b0) $display("FAIL t4_done_len: got %b, required 0", done_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL t4_busy_after: got %b, required 0", busy_o); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (n_acc !== 0) $display("FAIL t4_no_req: got %0d, required 0", n_acc); else n_pass++;
  endtask

  task automatic test_reset_midburst();
    clear_log();
    rsp_en = 0;
    start_burst(32'h0000_4000, 16'd6, 0);
    for (int i = 0; i < 20 && n_acc < 2; i++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (n_acc !== 2) $display("FAIL t5_outst: got %0d, required 2", n_acc); else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.req !== 1'b0) $display("FAIL t5_req: got %b, required 0", bus.req); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL t5_busy: got %b, required 0", busy_o); else n_pass++;
    n_checks++; if (rvalid_o !== 1'b0) $display("FAIL t5_rvalid: got %b, required 0", rvalid_o); else n_pass++;
    rst_n = 1'b1;
    rsp_en = 1;
    for (int i = 0; i < 20 && pend_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rvalid_o !== 1'b0) $display("FAIL t5_late_ignored: got %b, required 0", rvalid_o); else n_pass++;
    clear_log();
    start_burst(32'h0000_5000, 16'd2, 2);
    wait_done(50, "t5");
    n_checks++; if (n_beats !== 2) $display("FAIL t5_fresh_beats: got %0d, required 2", n_beats); else n_pass++;
    n_checks++; if (n_acc !== 2) $display("FAIL t5_fresh_reqs: got %0d, required 2", n_acc); else n_pass++;
  endtask

`ifdef NDMA_RD_ERR_EN
  task automatic test_err();
    int a_at_end;
    clear_log();
    rsp_idx = 0;
    err_at  = 2;
    start_burst(32'h0000_6000, 16'd6, 2);
    wait_done(60, "t6");
    err_at = -1;
    a_at_end = n_acc;
    n_checks++; if (err_o !== 1'b1) $display("FAIL t6_err: got %b, required 1", err_o); else n_pass++;
    n_checks++; if (n_beats !== 2) $display("FAIL t6_beats: got %0d, required 2", n_beats); else n_pass++;
    n_checks++; if (n_acc !== 4) $display("FAIL t6_reqs: got %0d, required 4", n_acc); else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (n_acc !== a_at_end) $display("FAIL t6_no_more_req: got %0d, required %0d", n_acc, a_at_end); else n_pass++;
    n_checks++; if (err_o !== 1'b1) $display("FAIL t6_err_sticky: got %b, required 1", err_o); else n_pass++;
    start_burst(32'h0000_7000, 16'd1, 1);
    n_checks++; if (err_o !== 1'b0) $display("FAIL t6_err_clear: got %b, required 0", err_o); else n_pass++;
    wait_done(50, "t6b");
  endtask
`else
  task automatic test_err();
    clear_log();
    rsp_idx = 0;
    err_at  = 2;
    start_burst(32'h0000_6000, 16'd4, 4);
    wait_done(60, "t6");
    err_at = -1;
    n_checks++; if (err_o !== 1'b0) $display("FAIL t6_err_tied: got %b, required 0", err_o); else n_pass++;
    n_checks++; if (n_beats !== 4) $display("FAIL t6_beats: got %0d, required 4", n_beats); else n_pass++;
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] b;
    logic [15:0] l;
    gnt_rand = 1; rsp_rand = 1; rr_rand = 1;
    for (int k = 0; k < 6; k++) begin
      clear_log();
      b = $urandom & 32'hFFFF_FFFC;
      l = 16'($urandom_range(1, 10));
      start_burst(b, l, int'(l));
      wait_done(400, "b2b");
      n_checks++; if (n_beats !== int'(l)) $display("FAIL b2b_beats%0d: got %0d, required %0d", k, n_beats, l); else n_pass++;
      n_checks++; if (acc_addr_q.size() !== int'(l)) $display("FAIL b2b_reqs%0d: got %0d, required %0d", k, acc_addr_q.size(), l); else n_pass++;
      for (int i = 0; i < acc_addr_q.size() && i < int'(l); i++) begin
        n_checks++;
        if (acc_addr_q[i] !== b + 32'(i) * 4) $display("FAIL b2b_addr%0d_%0d: got %h, required %h", k, i, acc_addr_q[i], b + 32'(i) * 4);
        else n_pass++;
      end
    end
    gnt_rand = 0; rsp_rand = 0; rr_rand = 0;
    rready = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_empty();
    test_reset_midburst();
    test_err();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL leftover_beats: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
